q_regfile_wb: RTL and testbench

Register file at the write-back end of the data path: it accepts the 64-bit result selected by the write-back source selector and commits it to 32 general registers. It also tracks quantum measurements whose results arrive later. Destination registers of outstanding measurements are held in an in-order pending queue. Each result returned on a valid/ready channel is committed to the head entry's register. The block stalls the pipeline on any hazard against a pending register.

---
 rtl/q_regfile_wb.sv | 72 +++++++
 tb/tb_q_regfile_wb.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/q_regfile_wb.sv
// q_regfile_wb: write-back register file with an in-order pending-measurement queue and hazard stall.
module q_regfile_wb #(
  parameter int DW     = 64,
  parameter int AW     = 5,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW-1:0]             i_rs1_addr,
  input  logic [AW-1:0]             i_rs2_addr,
  output logic [DW-1:0]             o_rs1_data,
  output logic [DW-1:0]             o_rs2_data,
  input  logic                      i_wr_en,
  input  logic [AW-1:0]             i_wr_addr,
  input  logic [DW-1:0]             i_wr_data,
  input  logic                      i_mea_issue,
  input  logic [AW-1:0]             i_mea_rd,
  input  logic                      i_mea_valid,
  input  logic [DW-1:0]             i_mea_data,
  output logic                      o_mea_ready,
  output logic                      o_stall,
  output logic [$clog2(QDEPTH):0]   o_pending_cnt
);
  localparam int NR = 1 << AW;
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
  logic [DW-1:0] regs_q [NR];
  logic [AW-1:0] rd_q [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [NR-1:0] pend;
  logic [QDEPTH-1:0] ent_v;
  logic wr_act, push, pop;
  // an entry is live when its distance from head is below the count
  for (genvar e = 0; e < QDEPTH; e++) begin : g_ent
    logic [PW-1:0] off;
    assign off = PW'(e) - head_q;
    assign ent_v[e] = {1'b0, off} < cnt_q;
  end
  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) if (ent_v[i]) pend[rd_q[i]] = 1'b1;
    pend[0] = 1'b0;
  end
  assign wr_act = i_wr_en && i_wr_addr != '0;
  assign o_stall = pend[i_rs1_addr] || pend[i_rs2_addr] || (i_wr_en && pend[i_wr_addr])
                || (i_mea_issue && (pend[i_mea_rd] || cnt_q == FULL));
  assign o_mea_ready = cnt_q != '0 && !wr_act;
  assign pop = i_mea_valid && o_mea_ready;
  assign push = i_mea_issue && !o_stall;
  assign head_d = head_q + PW'(pop);
  assign tail_d = tail_q + PW'(push);
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign o_pending_cnt = cnt_q;
  assign o_rs1_data = (wr_act && i_wr_addr == i_rs1_addr) ? i_wr_data : regs_q[i_rs1_addr];
  assign o_rs2_data = (wr_act && i_wr_addr == i_rs2_addr) ? i_wr_data : regs_q[i_rs2_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_act && !o_stall) regs_q[i_wr_addr] <= i_wr_data;
      if (pop && rd_q[head_q] != '0) regs_q[rd_q[head_q]] <= i_mea_data;
      if (push) rd_q[tail_q] <= i_mea_rd;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_q_regfile_wb.sv
// tb_q_regfile_wb: scenario tasks with a queue of expected register contents checked on readback.
module tb_q_regfile_wb;
  logic clk = 0, rst;
  logic [4:0] i_rs1_addr, i_rs2_addr, i_wr_addr, i_mea_rd;
  logic [63:0] o_rs1_data, o_rs2_data, i_wr_data, i_mea_data;
  logic i_wr_en, i_mea_issue, i_mea_valid, o_mea_ready, o_stall;
  logic [2:0] o_pending_cnt;
  typedef struct packed { logic [4:0] a; logic [63:0] d; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0;

  q_regfile_wb dut (.clk(clk), .rst(rst), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_mea_issue(i_mea_issue), .i_mea_rd(i_mea_rd), .i_mea_valid(i_mea_valid),
    .i_mea_data(i_mea_data), .o_mea_ready(o_mea_ready), .o_stall(o_stall), .o_pending_cnt(o_pending_cnt));

  always #5 clk = ~clk;

  task tick; @(posedge clk); #1; endtask
  task idle;
    rst = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0;
    i_mea_issue = 0; i_mea_rd = 0; i_mea_valid = 0; i_mea_data = 0;
  endtask

  task test_reset;
    idle(); rst = 1; tick(); rst = 0; i_rs1_addr = 5; i_rs2_addr = 9; #1;
    checks++; if (o_rs1_data !== 64'h0) begin errors++; $display("FAIL reset_rs1 got %h exp 0", o_rs1_data); end
    checks++; if (o_rs2_data !== 64'h0) begin errors++; $display("FAIL reset_rs2 got %h exp 0", o_rs2_data); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_stall); end
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_pending_cnt); end
    checks++; if (o_mea_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", o_mea_ready); end
    i_mea_valid = 1; i_mea_data = 64'h77; #1;
    checks++; if (o_mea_ready !== 1'b0) begin errors++; $display("FAIL empty_ready got %b exp 0", o_mea_ready); end
    tick(); i_mea_valid = 0; #1;
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL empty_cnt got %0d exp 0", o_pending_cnt); end
  endtask

  task test_write_bypass;
    idle(); i_wr_en = 1; i_wr_addr = 5; i_wr_data = 64'hDEAD_BEEF; i_rs1_addr = 5; #1;
    checks++; if (o_rs1_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass got %h exp deadbeef", o_rs1_data); end
    tick(); i_wr_en = 0; #1;
    checks++; if (o_rs1_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_commit got %h exp deadbeef", o_rs1_data); end
    i_wr_en = 1; i_wr_addr = 0; i_wr_data = 64'hFF; i_rs1_addr = 0; #1;
    checks++; if (o_rs1_data !== 64'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", o_rs1_data); end
    tick(); i_wr_en = 0; #1;
    checks++; if (o_rs1_data !== 64'h0) begin errors++; $display("FAIL r0_write got %h exp 0", o_rs1_data); end
    for (int a = 1; a <= 8; a++) begin
      i_wr_en = 1; i_wr_addr = 5'(a); i_wr_data = {$urandom, $urandom};
      exp_q.push_back('{a: 5'(a), d: i_wr_data}); tick();
    end
    i_wr_en = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); i_rs2_addr = e.a; #1;
      checks++; if (o_rs2_data !== e.d) begin errors++; $display("FAIL wr_r%0d got %h exp %h", e.a, o_rs2_data, e.d); end
    end
  endtask

  task test_hazard;
    idle(); i_mea_issue = 1; i_mea_rd = 7; i_rs1_addr = 7; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL issue_cycle_stall got %b exp 0", o_stall); end
    tick(); i_mea_issue = 0; #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b exp 1", o_stall); end
    checks++; if (o_mea_ready !== 1'b1) begin errors++; $display("FAIL hz_ready got %b exp 1", o_mea_ready); end
    checks++; if (o_pending_cnt !== 3'd1) begin errors++; $display("FAIL hz_cnt got %0d exp 1", o_pending_cnt); end
    i_mea_valid = 1; i_mea_data = 64'h1; exp_q.push_back('{a: 5'd7, d: 64'h1});
    tick(); i_mea_valid = 0; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hz_unstall got %b exp 0", o_stall); end
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL hz_cnt0 got %0d exp 0", o_pending_cnt); end
    e = exp_q.pop_front(); i_rs1_addr = e.a; #1;
    checks++; if (o_rs1_data !== e.d) begin errors++; $display("FAIL hz_r7 got %h exp %h", o_rs1_data, e.d); end
  endtask

  task test_port_conflict;
    idle(); i_mea_issue = 1; i_mea_rd = 3; tick(); i_mea_issue = 0;
    i_mea_valid = 1; i_mea_data = 64'hA; i_wr_en = 1; i_wr_addr = 4; i_wr_data = 64'h4444; #1;
    checks++; if (o_mea_ready !== 1'b0) begin errors++; $display("FAIL pc_ready got %b exp 0", o_mea_ready); end
    tick(); i_wr_en = 0; i_rs2_addr = 4; #1;
    checks++; if (o_rs2_data !== 64'h4444) begin errors++; $display("FAIL pc_r4 got %h exp 4444", o_rs2_data); end
    checks++; if (o_mea_ready !== 1'b1) begin errors++; $display("FAIL pc_ready2 got %b exp 1", o_mea_ready); end
    checks++; if (o_pending_cnt !== 3'd1) begin errors++; $display("FAIL pc_cnt1 got %0d exp 1", o_pending_cnt); end
    exp_q.push_back('{a: 5'd3, d: 64'hA});
    tick(); i_mea_valid = 0; #1;
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL pc_cnt0 got %0d exp 0", o_pending_cnt); end
    e = exp_q.pop_front(); i_rs1_addr = e.a; #1;
    checks++; if (o_rs1_data !== e.d) begin errors++; $display("FAIL pc_r3 got %h exp %h", o_rs1_data, e.d); end
  endtask

  task test_queue_full;
    idle();
    for (int r = 1; r <= 4; r++) begin i_mea_issue = 1; i_mea_rd = 5'(r); tick(); end
    i_mea_issue = 0; #1;
    checks++; if (o_pending_cnt !== 3'd4) begin errors++; $display("FAIL qf_cnt4 got %0d exp 4", o_pending_cnt); end
    i_mea_issue = 1; i_mea_rd = 9; #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL qf_full_stall got %b exp 1", o_stall); end
    i_mea_valid = 1; i_mea_data = 64'h11; #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL qf_full_pop_stall got %b exp 1", o_stall); end
    exp_q.push_back('{a: 5'd1, d: 64'h11});
    tick(); i_mea_issue = 0; i_mea_valid = 0; #1;
    checks++; if (o_pending_cnt !== 3'd3) begin errors++; $display("FAIL qf_cnt3 got %0d exp 3", o_pending_cnt); end
    i_mea_issue = 1; i_mea_rd = 9; i_mea_valid = 1; i_mea_data = 64'h22; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL qf_pushpop_stall got %b exp 0", o_stall); end
    exp_q.push_back('{a: 5'd2, d: 64'h22});
    tick(); i_mea_issue = 0; #1;
    checks++; if (o_pending_cnt !== 3'd3) begin errors++; $display("FAIL qf_pushpop_cnt got %0d exp 3", o_pending_cnt); end
    i_mea_data = 64'h33; exp_q.push_back('{a: 5'd3, d: 64'h33}); tick();
    i_mea_data = 64'h44; exp_q.push_back('{a: 5'd4, d: 64'h44}); tick();
    i_mea_data = 64'h99; exp_q.push_back('{a: 5'd9, d: 64'h99}); tick();
    i_mea_valid = 0; #1;
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL qf_cnt0 got %0d exp 0", o_pending_cnt); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); i_rs1_addr = e.a; #1;
      checks++; if (o_rs1_data !== e.d) begin errors++; $display("FAIL qf_r%0d got %h exp %h", e.a, o_rs1_data, e.d); end
    end
  endtask

  task test_mid_reset;
    idle(); i_mea_issue = 1; i_mea_rd = 10; tick(); i_mea_rd = 11; tick(); i_mea_issue = 0; #1;
    checks++; if (o_pending_cnt !== 3'd2) begin errors++; $display("FAIL mr_cnt2 got %0d exp 2", o_pending_cnt); end
    i_mea_valid = 1; i_mea_data = 64'hBAD; rst = 1; tick(); rst = 0; i_mea_valid = 0; #1;
    checks++; if (o_pending_cnt !== 3'd0) begin errors++; $display("FAIL mr_cnt0 got %0d exp 0", o_pending_cnt); end
    checks++; if (o_mea_ready !== 1'b0) begin errors++; $display("FAIL mr_ready got %b exp 0", o_mea_ready); end
    for (int a = 0; a < 32; a++) begin
      i_rs1_addr = 5'(a); #1;
      checks++; if (o_rs1_data !== 64'h0) begin errors++; $display("FAIL mr_r%0d got %h exp 0", a, o_rs1_data); end
    end
    i_rs1_addr = 10; i_rs2_addr = 11; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL mr_stall got %b exp 0", o_stall); end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_bypass();
    test_hazard();
    test_port_conflict();
    test_queue_full();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
